// File: rtl/i_queue_mp_if.sv
// Fetch/decode handshake bundle for the multi-port instruction queue.
// master = fetch+decode side, slave = the queue itself.
//   w_valid/w_data/w_ready : write lanes from fetch
//   r_valid/r_data/r_pop   : read lanes to decode
interface i_queue_mp_if #(
    parameter int DATA_W = 64,
    parameter int WPORTS = 2,
    parameter int RPORTS = 2
);
    logic [WPORTS-1:0]        w_valid;
    logic [WPORTS*DATA_W-1:0] w_data;
    logic                     w_ready;
    logic [RPORTS-1:0]        r_valid;
    logic [RPORTS*DATA_W-1:0] r_data;
    logic [RPORTS-1:0]        r_pop;

    modport master (
        output w_valid, w_data, r_pop,
        input  w_ready, r_valid, r_data
    );

    modport slave (
        input  w_valid, w_data, r_pop,
        output w_ready, r_valid, r_data
    );
endinterface

// File: rtl/i_queue_mp.sv
// Multi-port instruction queue: up to WPORTS writes and RPORTS pops per cycle.
// Ports: clk, rst_n (async, active-low), flush, q (slave handshake bundle),
//        count (occupancy), almost_full (count >= AF_LVL), proto_err (sticky).
module i_queue_mp #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 16,
    parameter int WPORTS = 2,
    parameter int RPORTS = 2,
    parameter int AF_LVL = 12
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    i_queue_mp_if.slave            q,
    output logic [$clog2(DEPTH):0] count,
    output logic                   almost_full,
    output logic                   proto_err
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PW-1:0] w_ptr;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] n_w;
    logic [PW-1:0] n_p;
    logic [PW-1:0] count_next;
    logic [PW-1:0] free_next;

    logic w_rdy_q;
    logic af_q;
    logic err_q;
    logic wr_en;
    logic w_gap;
    logic p_gap;
    logic p_bad;

    logic [RPORTS-1:0]        present;
    logic [RPORTS*DATA_W-1:0] r_data_c;

    assign count       = w_ptr - r_ptr;
    assign almost_full = af_q;
    assign proto_err   = err_q;

    // Registered readiness is additionally masked while a flush is active.
    assign q.w_ready = w_rdy_q & ~flush;
    assign wr_en     = w_rdy_q & ~flush & (|q.w_valid);

    // A lane vector is contiguous from lane 0 iff v & (v+1) == 0.
    assign w_gap = |({1'b0, q.w_valid} &
                     ({1'b0, q.w_valid} + (WPORTS+1)'(1)));
    assign p_gap = |({1'b0, q.r_pop} &
                     ({1'b0, q.r_pop} + (RPORTS+1)'(1)));

    always_comb begin
        present = '0;
        for (int i = 0; i < RPORTS; i++) begin
            present[i] = count > PW'(i);
        end
    end

    assign q.r_valid = present & {RPORTS{~flush}};

    always_comb begin
        logic [AW-1:0] idx;
        r_data_c = '0;
        idx      = '0;
        for (int i = 0; i < RPORTS; i++) begin
            idx = r_ptr[AW-1:0] + AW'(i);
            if (q.r_valid[i]) begin
                r_data_c[i*DATA_W +: DATA_W] = mem[idx];
            end
        end
    end

    assign q.r_data = r_data_c;

    // Non-contiguous w_valid still writes popcount lanes from lane 0.
    always_comb begin
        n_w = '0;
        if (wr_en) begin
            for (int i = 0; i < WPORTS; i++) begin
                n_w = n_w + PW'(q.w_valid[i]);
            end
        end
    end

    // Pops count only leading lanes that hold an entry. Validity here is
    // judged by occupancy, so pops issued during a flush are simply
    // discarded with the flush rather than flagged.
    always_comb begin
        logic stop;
        n_p   = '0;
        p_bad = 1'b0;
        stop  = 1'b0;
        for (int i = 0; i < RPORTS; i++) begin
            if (!q.r_pop[i]) begin
                stop = 1'b1;
            end else if (!present[i]) begin
                p_bad = 1'b1;
                stop  = 1'b1;
            end else if (!stop) begin
                n_p = n_p + PW'(1);
            end
        end
    end

    always_comb begin
        if (flush) begin
            count_next = '0;
        end else begin
            count_next = count + n_w - n_p;
        end
        free_next = PW'(DEPTH) - count_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            w_rdy_q <= 1'b0;
            af_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (flush) begin
                w_ptr <= '0;
                r_ptr <= '0;
            end else begin
                w_ptr <= w_ptr + n_w;
                r_ptr <= r_ptr + n_p;
            end
            w_rdy_q <= ~flush & (free_next >= PW'(WPORTS));
            af_q    <= count_next >= PW'(AF_LVL);
            if (w_gap | p_gap | p_bad) begin
                err_q <= 1'b1;
            end
        end
    end

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < WPORTS; i++) begin
                if (PW'(i) < n_w) begin
                    mem[w_ptr[AW-1:0] + AW'(i)] <=
                        q.w_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end
endmodule

// File: tb/tb_i_queue_mp.sv
// Self-checking bench for i_queue_mp (DEPTH=16, 2 write / 2 read lanes).
// Table of directed vectors plus hand sequences, checked against a FIFO model.
module tb_i_queue_mp;
    localparam int DW = 64;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic [4:0] count;
    logic       almost_full;
    logic       proto_err;

    i_queue_mp_if #(.DATA_W(DW), .WPORTS(2), .RPORTS(2)) bus ();

    i_queue_mp #(
        .DATA_W(DW), .DEPTH(16), .WPORTS(2), .RPORTS(2), .AF_LVL(12)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .q           (bus),
        .count       (count),
        .almost_full (almost_full),
        .proto_err   (proto_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] wv;
        logic [1:0] pop;
        logic       fl;
        int         cnt;
        int         rdy;
    } vec_t;

    vec_t          tab[$];
    logic [DW-1:0] sb[$];
    int errors = 0;
    int checks = 0;
    int seq    = 0;
    logic m_rdy = 1'b0;
    logic m_af  = 1'b0;
    logic m_err = 1'b0;

    function automatic logic [DW-1:0] mk(input int s);
        return {32'(s) * 32'd4 + 32'h1000, 32'(s) ^ 32'h1357_9bdf};
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_rdy = 1'b0;
        m_af  = 1'b0;
        m_err = 1'b0;
    endtask

    // One cycle: drive at negedge, check pre-edge outputs, advance model.
    // t_cnt/t_rdy are table expectations (-1 = none).
    task automatic step(input logic [1:0] wv, input logic [1:0] pop,
                        input logic fl, input int t_cnt, input int t_rdy);
        logic rdy_out;
        logic vld;
        logic bad;
        logic stop;
        int   nw;
        int   np;
        @(negedge clk);
        bus.w_valid = wv;
        bus.w_data  = {mk(seq + 1), mk(seq)};
        bus.r_pop   = pop;
        flush       = fl;
        #1;
        rdy_out = m_rdy & ~fl;
        chk("w_ready", 64'(bus.w_ready), 64'(rdy_out));
        chk("count", 64'(count), 64'(sb.size()));
        chk("almost_full", 64'(almost_full), 64'(m_af));
        chk("proto_err", 64'(proto_err), 64'(m_err));
        if (t_cnt >= 0) chk("tab_count", 64'(count), 64'(t_cnt));
        if (t_rdy >= 0) chk("tab_w_ready", 64'(bus.w_ready), 64'(t_rdy));
        for (int i = 0; i < 2; i++) begin
            vld = (sb.size() > i) && !fl;
            chk($sformatf("r_valid%0d", i), 64'(bus.r_valid[i]), 64'(vld));
            chk($sformatf("r_data%0d", i), bus.r_data[i*DW +: DW],
                vld ? sb[i] : 64'h0);
        end
        nw   = rdy_out ? (int'(wv[0]) + int'(wv[1])) : 0;
        np   = 0;
        bad  = 1'b0;
        stop = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (!pop[i]) stop = 1'b1;
            else if (sb.size() <= i) begin
                bad  = 1'b1;
                stop = 1'b1;
            end else if (!stop) np++;
        end
        if (wv == 2'b10 || pop == 2'b10 || bad) m_err = 1'b1;
        if (fl) begin
            sb.delete();
        end else begin
            for (int i = 0; i < np; i++) void'(sb.pop_front());
            for (int i = 0; i < nw; i++) sb.push_back(mk(seq + i));
            seq += nw;
        end
        m_rdy = !fl && (16 - sb.size() >= 2);
        m_af  = !fl && (sb.size() >= 12);
        @(posedge clk);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic check_reset_state();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_r_valid", 64'(bus.r_valid), 64'd0);
        chk("rst_w_ready", 64'(bus.w_ready), 64'd0);
        chk("rst_almost_full", 64'(almost_full), 64'd0);
        chk("rst_proto_err", 64'(proto_err), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int nwr;
        int npr;
        logic [1:0] wv;
        rst_n       = 1'b0;
        flush       = 1'b0;
        bus.w_valid = '0;
        bus.w_data  = '0;
        bus.r_pop   = '0;
        model_reset();
        #13;
        check_reset_state();
        release_reset();
        step(2'b00, 2'b00, 1'b0, 0, 0);

        // Reset mid-traffic at count 5
        step(2'b11, 2'b00, 1'b0, 0, 1);
        step(2'b11, 2'b00, 1'b0, 2, 1);
        step(2'b01, 2'b00, 1'b0, 4, 1);
        @(negedge clk);
        bus.w_valid = '0;
        #1 chk("pre_rst_count", 64'(count), 64'd5);
        rst_n = 1'b0;
        #1 check_reset_state();
        model_reset();
        release_reset();
        step(2'b00, 2'b00, 1'b0, 0, 0);

        // Fill to 16, 9th write dropped, then mixed push/pop at 15
        for (int k = 0; k < 9; k++) begin
            tab.push_back('{2'b11, 2'b00, 1'b0, 2 * k, (k < 8) ? 1 : 0});
        end
        tab.push_back('{2'b00, 2'b00, 1'b0, 16, 0});
        tab.push_back('{2'b00, 2'b01, 1'b0, 16, 0});
        tab.push_back('{2'b11, 2'b11, 1'b0, 15, 0});
        tab.push_back('{2'b00, 2'b00, 1'b0, 13, 1});
        foreach (tab[k]) begin
            step(tab[k].wv, tab[k].pop, tab[k].fl, tab[k].cnt, tab[k].rdy);
        end

        // Random push/pop across pointer wrap
        for (int k = 0; k < 40; k++) begin
            nwr = $urandom_range(0, 2);
            npr = $urandom_range(0, 2);
            if (npr > sb.size()) npr = sb.size();
            wv = (nwr == 0) ? 2'b00 : (nwr == 1) ? 2'b01 : 2'b11;
            step(wv, (npr == 0) ? 2'b00 : (npr == 1) ? 2'b01 : 2'b11,
                 1'b0, -1, -1);
            chk("count_bound", 64'(count <= 5'd16), 64'd1);
        end

        // Flush at count 9
        for (int k = 0; k < 20 && sb.size() > 0; k++) begin
            step(2'b00, (sb.size() >= 2) ? 2'b11 : 2'b01, 1'b0, -1, -1);
        end
        step(2'b11, 2'b00, 1'b0, 0, 1);
        step(2'b11, 2'b00, 1'b0, 2, 1);
        step(2'b11, 2'b00, 1'b0, 4, 1);
        step(2'b11, 2'b00, 1'b0, 6, 1);
        step(2'b01, 2'b00, 1'b0, 8, 1);
        step(2'b11, 2'b01, 1'b1, 9, 0);
        step(2'b00, 2'b00, 1'b0, 0, 0);
        step(2'b11, 2'b00, 1'b0, 0, 1);
        step(2'b00, 2'b11, 1'b0, 2, 1);

        // Protocol error: pop lane 1 without lane 0
        step(2'b11, 2'b00, 1'b0, 0, 1);
        step(2'b01, 2'b00, 1'b0, 2, 1);
        step(2'b00, 2'b10, 1'b0, 3, 1);
        step(2'b00, 2'b00, 1'b0, 3, 1);
        chk("proto_err_set", 64'(proto_err), 64'd1);
        step(2'b00, 2'b00, 1'b1, 3, 0);
        step(2'b00, 2'b00, 1'b0, 0, 0);
        chk("proto_err_sticky", 64'(proto_err), 64'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1 chk("proto_err_cleared", 64'(proto_err), 64'd0);
        model_reset();
        release_reset();
        step(2'b00, 2'b00, 1'b0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
